// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the core/debug memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_C = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  localparam logic [1:0] OWNER_IDLE  = 2'b00;
  localparam logic [1:0] OWNER_CORE  = 2'b01;
  localparam logic [1:0] OWNER_DEBUG = 2'b10;

  localparam logic [1:0] OP_SIZE_BYTE = 2'b00;
  localparam logic [1:0] OP_SIZE_HALF = 2'b01;
  localparam logic [1:0] OP_SIZE_WORD = 2'b10;

  localparam logic [2:0] FAULT_NONE = 3'd0;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester, response and downstream memory signals around the arbiter.
interface mem_bus_arbiter_if;
  import mem_arb_pkg::*;

  logic        c_req, c_is_write, c_is_unsigned, c_ack;
  logic [1:0]  c_op_size;
  logic [31:0] c_addr, c_wdata;

  logic        d_req, d_is_write, d_is_unsigned, d_ack;
  logic [1:0]  d_op_size;
  logic [31:0] d_addr, d_wdata;

  logic [31:0] rdata;
  logic [2:0]  fault_num;
  logic [1:0]  owner;

  logic        mem_req, mem_is_write, mem_is_unsigned, mem_ready;
  logic [1:0]  mem_op_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_fault_num;

  // Arbiter side: serves the two requesters and masters the memory port.
  modport slave (
    input  c_req, c_is_write, c_is_unsigned, c_op_size, c_addr, c_wdata,
    input  d_req, d_is_write, d_is_unsigned, d_op_size, d_addr, d_wdata,
    input  mem_ready, mem_rdata, mem_fault_num,
    output c_ack, d_ack, rdata, fault_num, owner,
    output mem_req, mem_is_write, mem_is_unsigned, mem_op_size, mem_addr, mem_wdata
  );

  // Environment side: requesters and the memory model.
  modport master (
    output c_req, c_is_write, c_is_unsigned, c_op_size, c_addr, c_wdata,
    output d_req, d_is_write, d_is_unsigned, d_op_size, d_addr, d_wdata,
    output mem_ready, mem_rdata, mem_fault_num,
    input  c_ack, d_ack, rdata, fault_num, owner,
    input  mem_req, mem_is_write, mem_is_unsigned, mem_op_size, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_counter.sv
// Saturating up-counter with synchronous clear; reports when it sits at MAX.
module mem_arb_counter #(
  parameter int           W   = 4,
  parameter logic [W-1:0] MAX = {W{1'b1}}
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_sat
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_sat) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_sat = (r_count == MAX);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fixed-priority core/debug arbiter for the single memory port, with a
// starvation guard for the debug port and a downstream timeout.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int         MAX_STREAK     = 4,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [2:0] TIMEOUT_FAULT  = 3'd7
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.slave  bus
);

  localparam int STREAK_W = cnt_width(MAX_STREAK);
  localparam int TO_W     = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  arb_state_e r_state;

  logic w_arb, w_grant_c, w_grant_d, w_streak_sat;
  logic w_busy, w_to_en, w_to_last, w_timeout;

  // Core wins unless the debug port has already waited MAX_STREAK core grants.
  assign w_arb     = (r_state == ST_IDLE);
  assign w_grant_c = w_arb && bus.c_req && (!bus.d_req || !w_streak_sat);
  assign w_grant_d = w_arb && bus.d_req && !w_grant_c;

  assign w_busy    = ((r_state == ST_BUSY_C) || (r_state == ST_BUSY_D)) && bus.mem_req;
  assign w_to_en   = w_busy && !bus.mem_ready && (TIMEOUT_CYCLES != 0);
  // The counter rests at TIMEOUT_CYCLES-1; one more idle wait is the abort.
  assign w_timeout = w_to_en && w_to_last;

  mem_arb_counter #(.W(STREAK_W), .MAX(STREAK_W'(MAX_STREAK))) u_streak (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_arb && (!bus.d_req || w_grant_d)),
    .i_en  (w_grant_c && bus.d_req),
    .o_sat (w_streak_sat)
  );

  mem_arb_counter #(.W(TO_W), .MAX(TO_LAST)) u_timeout (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_grant_c || w_grant_d),
    .i_en  (w_to_en),
    .o_sat (w_to_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state             <= ST_IDLE;
      bus.c_ack           <= 1'b0;
      bus.d_ack           <= 1'b0;
      bus.rdata           <= '0;
      bus.fault_num       <= FAULT_NONE;
      bus.owner           <= OWNER_IDLE;
      bus.mem_req         <= 1'b0;
      bus.mem_is_write    <= 1'b0;
      bus.mem_is_unsigned <= 1'b0;
      bus.mem_op_size     <= '0;
      bus.mem_addr        <= '0;
      bus.mem_wdata       <= '0;
    end else begin
      bus.c_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_c) begin
            bus.mem_is_write    <= bus.c_is_write;
            bus.mem_is_unsigned <= bus.c_is_unsigned;
            bus.mem_op_size     <= bus.c_op_size;
            bus.mem_addr        <= bus.c_addr;
            bus.mem_wdata       <= bus.c_wdata;
            bus.mem_req         <= 1'b1;
            bus.owner           <= OWNER_CORE;
            r_state             <= ST_BUSY_C;
          end else if (w_grant_d) begin
            bus.mem_is_write    <= bus.d_is_write;
            bus.mem_is_unsigned <= bus.d_is_unsigned;
            bus.mem_op_size     <= bus.d_op_size;
            bus.mem_addr        <= bus.d_addr;
            bus.mem_wdata       <= bus.d_wdata;
            bus.mem_req         <= 1'b1;
            bus.owner           <= OWNER_DEBUG;
            r_state             <= ST_BUSY_D;
          end
        end
        ST_BUSY_C, ST_BUSY_D: begin
          if (bus.mem_ready || w_timeout) begin
            bus.mem_req   <= 1'b0;
            bus.rdata     <= bus.mem_ready ? bus.mem_rdata : '0;
            bus.fault_num <= bus.mem_ready ? bus.mem_fault_num : TIMEOUT_FAULT;
            bus.c_ack     <= (r_state == ST_BUSY_C);
            bus.d_ack     <= (r_state == ST_BUSY_D);
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          bus.owner <= OWNER_IDLE;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-timing model.
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int         MAXS = 2;
  localparam int         TO   = 4;
  localparam logic [2:0] TOF  = 3'd7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.MAX_STREAK(MAXS), .TIMEOUT_CYCLES(TO), .TIMEOUT_FAULT(TOF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int r, input logic req, input logic w, input logic u,
                           input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    if (r == 0) begin
      bus.c_req = req; bus.c_is_write = w; bus.c_is_unsigned = u;
      bus.c_op_size = sz; bus.c_addr = addr; bus.c_wdata = wd;
    end else begin
      bus.d_req = req; bus.d_is_write = w; bus.d_is_unsigned = u;
      bus.d_op_size = sz; bus.d_addr = addr; bus.d_wdata = wd;
    end
  endtask

  task automatic quiet();
    drive_req(0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive_req(1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0; bus.mem_fault_num = 3'd0;
  endtask

  task automatic run_random(input int n_edges);
    logic [31:0] f_addr [2];
    logic [31:0] f_wd [2];
    logic        f_w [2];
    logic        f_u [2];
    logic [1:0]  f_sz [2];
    bit          pend [2];
    bit          drop [2];
    bit          busy, cq, dq, chk_owner, chk_fields, chk_resp;
    int          g, a, k, win, streak;
    logic [31:0] rsp_d;
    logic [2:0]  rsp_f;
    logic [1:0]  exp_ack, exp_owner;
    logic        exp_req;
    pend = '{0, 0}; drop = '{0, 0};
    busy = 0; streak = 0; g = 0; a = 0; k = 0; win = 0;
    rsp_d = '0; rsp_f = '0;
    for (int e = 0; e < n_edges; e++) begin
      // Requesters: hold fields until acked, then drop req for one cycle.
      for (int r = 0; r < 2; r++) begin
        if (drop[r]) drop[r] = 0;
        else if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1;
          f_addr[r] = $urandom; f_wd[r] = $urandom;
          f_w[r] = 1'($urandom_range(0, 1)); f_u[r] = 1'($urandom_range(0, 1));
          f_sz[r] = 2'($urandom_range(0, 2));
        end
        if (pend[r]) drive_req(r, 1'b1, f_w[r], f_u[r], f_sz[r], f_addr[r], f_wd[r]);
        else drive_req(r, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)), $urandom, $urandom);
      end
      // Memory: answer after k waits; outside the access window drive noise.
      if (busy && e > g && e <= a) begin
        bus.mem_ready = (k < TO) && (e == g + 1 + k);
        bus.mem_rdata = rsp_d; bus.mem_fault_num = rsp_f;
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom; bus.mem_fault_num = 3'($urandom_range(0, 7));
      end
      // Reference: one access occupies grant, k+1 memory cycles, ack, then a dead cycle.
      exp_ack = 2'b00; chk_owner = 1; chk_fields = 0; chk_resp = 0;
      if (!busy) begin
        cq = pend[0]; dq = pend[1]; win = 0;
        if (cq && (!dq || streak < MAXS)) begin win = 1; streak = dq ? streak + 1 : 0; end
        else if (dq) begin win = 2; streak = 0; end
        else streak = 0;
        if (win != 0) begin
          busy = 1; g = e; k = $urandom_range(0, TO + 1);
          a = (k < TO) ? g + 1 + k : g + TO;
          rsp_d = $urandom;
          rsp_f = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
          exp_req = 1'b1; exp_owner = 2'(win); chk_fields = 1;
        end else begin
          exp_req = 1'b0; exp_owner = 2'b00;
        end
      end else begin
        exp_req   = (e < a);
        exp_owner = (e == a + 1) ? 2'b00 : 2'(win);
        chk_owner = (e != a);
        if (e == a) begin
          exp_ack[win-1] = 1'b1; chk_resp = 1;
          pend[win-1] = 0; drop[win-1] = 1;
        end
        if (e == a + 1) busy = 0;
      end
      tick();
      chk("rnd_c_ack", bus.c_ack, exp_ack[0]);
      chk("rnd_d_ack", bus.d_ack, exp_ack[1]);
      chk("rnd_mem_req", bus.mem_req, exp_req);
      if (chk_owner) chk("rnd_owner", bus.owner, exp_owner);
      if (chk_fields) begin
        chk("rnd_mem_addr", bus.mem_addr, f_addr[win-1]);
        chk("rnd_mem_wdata", bus.mem_wdata, f_wd[win-1]);
        chk("rnd_mem_ctl", {bus.mem_is_write, bus.mem_is_unsigned, bus.mem_op_size},
            {f_w[win-1], f_u[win-1], f_sz[win-1]});
      end
      if (chk_resp) begin
        chk("rnd_rdata", bus.rdata, (k < TO) ? rsp_d : 32'h0);
        chk("rnd_fault", bus.fault_num, (k < TO) ? rsp_f : TOF);
      end
    end
  endtask

  int order [6] = '{1, 1, 2, 1, 1, 2};

  initial begin
    quiet();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_acks", {bus.c_ack, bus.d_ack}, 0);
    chk("rst_rdata", bus.rdata, 0);

    // Core read, memory ready on the first request cycle.
    drive_req(0, 1'b1, 1'b0, 1'b0, OP_SIZE_WORD, 32'h100, 32'h0);
    tick();
    chk("rd_mem_req", bus.mem_req, 1);
    chk("rd_owner", bus.owner, 1);
    chk("rd_mem_addr", bus.mem_addr, 32'h100);
    chk("rd_mem_size", bus.mem_op_size, OP_SIZE_WORD);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF; bus.mem_fault_num = 3'd0;
    tick();
    chk("rd_c_ack", bus.c_ack, 1);
    chk("rd_d_ack", bus.d_ack, 0);
    chk("rd_rdata", bus.rdata, 32'hDEADBEEF);
    chk("rd_fault", bus.fault_num, 0);
    chk("rd_mem_req_drop", bus.mem_req, 0);
    bus.c_req = 1'b0; bus.mem_ready = 1'b0;
    tick();
    chk("rd_ack_one_cycle", bus.c_ack, 0);
    chk("rd_owner_idle", bus.owner, 0);

    // Fault passthrough; request fields latched at grant.
    drive_req(0, 1'b1, 1'b0, 1'b0, OP_SIZE_WORD, 32'h3, 32'h0);
    tick();
    chk("lat_mem_addr", bus.mem_addr, 32'h3);
    bus.c_addr = 32'h8;
    tick();
    chk("lat_addr_hold", bus.mem_addr, 32'h3);
    chk("lat_mem_req", bus.mem_req, 1);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h12345678; bus.mem_fault_num = 3'd4;
    tick();
    chk("flt_c_ack", bus.c_ack, 1);
    chk("flt_fault", bus.fault_num, 4);
    bus.c_req = 1'b0; bus.mem_ready = 1'b0; bus.mem_fault_num = 3'd0;
    tick();

    // Debug write with memory never ready.
    drive_req(1, 1'b1, 1'b1, 1'b0, OP_SIZE_WORD, 32'h40, 32'hCAFEF00D);
    tick();
    chk("to_owner", bus.owner, 2);
    chk("to_is_write", bus.mem_is_write, 1);
    chk("to_wdata", bus.mem_wdata, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_mem_req_held", bus.mem_req, 1);
    end
    tick();
    chk("to_mem_req_drop", bus.mem_req, 0);
    chk("to_d_ack", bus.d_ack, 1);
    chk("to_c_ack", bus.c_ack, 0);
    chk("to_fault", bus.fault_num, TOF);
    chk("to_rdata", bus.rdata, 0);
    bus.d_req = 1'b0;
    tick();

    // Core keeps req high across its ack: seen as a new request.
    drive_req(0, 1'b1, 1'b0, 1'b1, OP_SIZE_BYTE, 32'h200, 32'h0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h55; bus.mem_fault_num = 3'd0;
    tick();
    chk("stk_grant", bus.mem_req, 1);
    tick();
    chk("stk_ack", bus.c_ack, 1);
    tick();
    chk("stk_resp_gap", bus.mem_req, 0);
    chk("stk_ack_low", bus.c_ack, 0);
    tick();
    chk("stk_regrant", bus.mem_req, 1);
    chk("stk_owner", bus.owner, 1);
    tick();
    chk("stk_ack2", bus.c_ack, 1);
    bus.c_req = 1'b0;
    tick();

    // Both ports held, memory always ready: debug forced through after MAXS core grants.
    drive_req(0, 1'b1, 1'b0, 1'b0, OP_SIZE_WORD, 32'h300, 32'h0);
    drive_req(1, 1'b1, 1'b0, 1'b0, OP_SIZE_HALF, 32'h400, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("sim_grant", bus.owner, order[i]);
      chk("sim_mem_req", bus.mem_req, 1);
      tick();
      chk("sim_acks", {bus.d_ack, bus.c_ack}, (order[i] == 1) ? 2'b01 : 2'b10);
      tick();
      chk("sim_gap", bus.mem_req, 0);
    end
    quiet();
    tick();

    // Reset while a core access is outstanding.
    drive_req(0, 1'b1, 1'b0, 1'b0, OP_SIZE_WORD, 32'h500, 32'h0);
    tick();
    chk("rstb_grant", bus.mem_req, 1);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rstb_mem_req", bus.mem_req, 0);
      chk("rstb_owner", bus.owner, 0);
      chk("rstb_mem_addr", bus.mem_addr, 0);
      chk("rstb_acks", {bus.c_ack, bus.d_ack}, 0);
    end
    reset = 1'b0; bus.c_req = 1'b0;
    tick();
    chk("rstb_no_ack", bus.c_ack, 0);
    chk("rstb_idle", bus.mem_req, 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_random(3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
